// File: rtl/if_stream_packer_if.sv
// Bundle of the pixel-input and FIFO-write signals around the IF stream packer.
// The master side is the pixel source / FIFO model and the slave side is the packer.
interface if_stream_packer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PAR_WRITE  = 16
);
    logic                             px_valid;
    logic [DATA_WIDTH-3:0]            px_data;
    logic                             px_last;
    logic                             frame_last;
    logic                             px_ready;
    logic [DATA_WIDTH*PAR_WRITE-1:0]  dout;
    logic                             wen;
    logic                             full;
    logic                             busy;
    logic                             frame_done;

    modport master (
        output px_valid, px_data, px_last, frame_last, full,
        input  px_ready, dout, wen, busy, frame_done
    );

    modport slave (
        input  px_valid, px_data, px_last, frame_last, full,
        output px_ready, dout, wen, busy, frame_done
    );
endinterface

// File: rtl/if_stream_packer.sv
// Transmit-side packer for the input-feature-map FIFO. Tags each pixel with a
// row-start and a row-end bit, collects PAR_WRITE tagged words into a burst,
// zero-pads a burst cut short by the end of a frame, and writes the burst to
// the FIFO parallel port once the FIFO is not full.
module if_stream_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int PAR_WRITE  = 16,
    parameter int IDX_WIDTH  = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    if_stream_packer_if.slave  bus
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PAR_WRITE - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

    state_t                               state_r;
    state_t                               state_nx;
    logic [IDX_WIDTH-1:0]                 idx_r;
    logic [IDX_WIDTH-1:0]                 idx_nx;
    logic                                 row_start_r;
    logic                                 frame_pending_r;
    logic                                 frame_done_r;
    logic [PAR_WRITE-1:0][DATA_WIDTH-1:0] slot_r;

    logic                                 take_s;
    logic                                 wen_s;
    logic                                 px_ready_s;
    logic                                 end_tag_s;

    // A frame end always closes the current row, even without px_last.
    assign end_tag_s = bus.px_last | bus.frame_last;

    // State and slot-index register; rst is asynchronous, clr is its synchronous twin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL;
            idx_r   <= '0;
        end else if (clr) begin
            state_r <= FILL;
            idx_r   <= '0;
        end else begin
            state_r <= state_nx;
            idx_r   <= idx_nx;
        end
    end

    // Next-state, slot index and handshake decode.
    always_comb begin
        state_nx   = state_r;
        idx_nx     = idx_r;
        px_ready_s = 1'b0;
        wen_s      = 1'b0;
        take_s     = 1'b0;
        case (state_r)
            FILL: begin
                px_ready_s = 1'b1;
                if (bus.px_valid) begin
                    take_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_nx = SEND;
                        idx_nx   = '0;
                    end else if (bus.frame_last) begin
                        // idx keeps pointing at the first empty slot for PAD
                        state_nx = PAD;
                        idx_nx   = idx_r + IDX_ONE;
                    end else begin
                        idx_nx   = idx_r + IDX_ONE;
                    end
                end else begin
                    state_nx = FILL;
                end
            end
            PAD: begin
                state_nx = SEND;
                idx_nx   = '0;
            end
            SEND: begin
                if (!bus.full) begin
                    wen_s    = 1'b1;
                    state_nx = FILL;
                end else begin
                    state_nx = SEND;
                end
            end
            default: begin
                state_nx = FILL;
                idx_nx   = '0;
            end
        endcase
    end

    // Burst slots, row/frame tracking flags and the frame_done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_r          <= '0;
            row_start_r     <= 1'b1;
            frame_pending_r <= 1'b0;
            frame_done_r    <= 1'b0;
        end else if (clr) begin
            slot_r          <= '0;
            row_start_r     <= 1'b1;
            frame_pending_r <= 1'b0;
            frame_done_r    <= 1'b0;
        end else begin
            frame_done_r <= wen_s & frame_pending_r;
            if (take_s) begin
                slot_r[idx_r] <= {row_start_r, end_tag_s, bus.px_data};
                row_start_r   <= end_tag_s;
                if (bus.frame_last) begin
                    frame_pending_r <= 1'b1;
                end
            end else if (state_r == PAD) begin
                // Clear stale words of the previous burst above the last pixel
                for (int i = 0; i < PAR_WRITE; i++) begin
                    if (IDX_WIDTH'(i) >= idx_r) begin
                        slot_r[i] <= '0;
                    end
                end
            end else if (wen_s && frame_pending_r) begin
                frame_pending_r <= 1'b0;
                row_start_r     <= 1'b1;
            end
        end
    end

    assign bus.px_ready   = px_ready_s;
    assign bus.wen        = wen_s;
    assign bus.dout       = slot_r;
    assign bus.busy       = (state_r != FILL) || (idx_r != '0);
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_if_stream_packer.sv
// Bench for if_stream_packer with PAR_WRITE=4: a pixel driver feeds a
// behavioural burst model, a monitor compares every FIFO write against it.
module tb_if_stream_packer;

    localparam int DW = 16;
    localparam int PW = 4;
    localparam int BW = DW * PW;

    logic clk;
    logic rst;
    logic clr;
    int   checks;
    int   failures;
    int   cyc;

    logic        full_forced;
    logic        rand_full_en;

    logic [DW-1:0] grp[$];
    bit            m_row_start;
    logic [BW-1:0] exp_q[$];
    bit            exp_fd_q[$];
    int            acc_cyc_q[$];

    if_stream_packer_if #(.DATA_WIDTH(DW), .PAR_WRITE(PW)) bus();

    if_stream_packer #(.DATA_WIDTH(DW), .PAR_WRITE(PW)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: a group closes after PW pixels or at a frame end, and
    // is then padded with zero words up to PW.
    function automatic void model_accept(input logic [DW-3:0] d, input logic l, input logic fl);
        logic [BW-1:0] burst;
        grp.push_back({m_row_start, l | fl, d});
        m_row_start = l | fl;
        if (grp.size() == PW || fl) begin
            while (grp.size() < PW) grp.push_back('0);
            burst = '0;
            for (int k = 0; k < PW; k++) burst[k*DW +: DW] = grp[k];
            exp_q.push_back(burst);
            exp_fd_q.push_back(fl);
            grp.delete();
            if (fl) m_row_start = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        grp.delete();
        exp_q.delete();
        exp_fd_q.delete();
        m_row_start = 1'b1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Offers one pixel until it is taken; returns on the negedge after acceptance.
    task automatic send_px(input logic [DW-3:0] d, input logic l, input logic fl);
        bit   acc;
        int   n;
        logic r;
        acc = 1'b0;
        n   = 0;
        bus.px_valid   = 1'b1;
        bus.px_data    = d;
        bus.px_last    = l;
        bus.frame_last = fl;
        while (!acc) begin
            #1;
            r = bus.px_ready;
            @(posedge clk);
            if (r) begin
                acc = 1'b1;
                model_accept(d, l, fl);
                acc_cyc_q.push_back(cyc);
            end
            @(negedge clk);
            n++;
            if (!acc && n > 50) begin
                checks++;
                failures++;
                $display("FAIL px_accept_timeout actual=not_taken expected=taken");
                break;
            end
        end
        bus.px_valid = 1'b0;
    endtask

    // FIFO full generator: random back-pressure or a directed level.
    initial begin
        bus.full = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            bus.full = rand_full_en ? ($urandom_range(0, 2) == 0) : full_forced;
        end
    end

    // Monitor: every FIFO write is checked against the oldest expected burst.
    initial begin
        bit fd_expect;
        fd_expect = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                fd_expect = 1'b0;
            end else begin
                if (bus.wen) check("wen_vs_full", {63'd0, bus.full}, 64'd0);
                if (bus.frame_done || fd_expect)
                    check("frame_done", {63'd0, bus.frame_done}, {63'd0, fd_expect});
                fd_expect = 1'b0;
                if (bus.wen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_wen actual=%h expected=no_write", bus.dout);
                    end else begin
                        check("burst", bus.dout, exp_q.pop_front());
                        fd_expect = exp_fd_q.pop_front();
                    end
                end
            end
        end
    end

    initial begin
        int span;
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        rst          = 1'b1;
        clr          = 1'b0;
        full_forced  = 1'b0;
        rand_full_en = 1'b0;
        bus.px_valid   = 1'b0;
        bus.px_data    = '0;
        bus.px_last    = 1'b0;
        bus.frame_last = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_px_ready",   {63'd0, bus.px_ready},   64'd1);
        check("rst_wen",        {63'd0, bus.wen},        64'd0);
        check("rst_busy",       {63'd0, bus.busy},       64'd0);
        check("rst_frame_done", {63'd0, bus.frame_done}, 64'd0);
        check("rst_dout",       bus.dout,                64'd0);

        // One 4-pixel row that ends the frame
        for (int i = 1; i <= 4; i++) send_px(14'(i), i == 4, i == 4);
        #2;
        check("t1_wen",  {63'd0, bus.wen}, 64'd1);
        check("t1_dout", bus.dout, 64'h4004_0003_0002_8001);
        tick();
        check("t1_frame_done", {63'd0, bus.frame_done}, 64'd1);
        check("t1_idle_busy",  {63'd0, bus.busy},       64'd0);

        // Two rows of 3 pixels: one full burst, one padded burst
        for (int i = 1; i <= 4; i++) send_px(14'(i), i == 3, 1'b0);
        #2;
        check("t2_b1_wen",  {63'd0, bus.wen}, 64'd1);
        check("t2_b1_dout", bus.dout, 64'h8004_4003_0002_8001);
        send_px(14'd5, 1'b0, 1'b0);
        send_px(14'd6, 1'b1, 1'b1);
        #2;
        check("t2_pad_wen",   {63'd0, bus.wen},      64'd0);
        check("t2_pad_ready", {63'd0, bus.px_ready}, 64'd0);
        tick();
        check("t2_b2_wen",  {63'd0, bus.wen}, 64'd1);
        check("t2_b2_dout", bus.dout, 64'h0000_0000_4006_0005);
        tick();
        check("t2_frame_done", {63'd0, bus.frame_done}, 64'd1);

        // FIFO full for 5 cycles after a group completes
        send_px(14'h11, 1'b0, 1'b0);
        send_px(14'h12, 1'b0, 1'b0);
        send_px(14'h13, 1'b0, 1'b0);
        full_forced = 1'b1;
        send_px(14'h14, 1'b1, 1'b0);
        #2;
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_wen",   {63'd0, bus.wen},      64'd0);
            check("t3_stall_ready", {63'd0, bus.px_ready}, 64'd0);
            check("t3_stall_dout",  bus.dout, 64'h4014_0013_0012_8011);
            @(negedge clk);
        end
        full_forced = 1'b0;
        #2;
        check("t3_release_wen", {63'd0, bus.wen}, 64'd1);
        tick();

        // Single-pixel rows across two bursts
        for (int i = 1; i <= 8; i++) send_px(14'(8'h30 + i), 1'b1, i == 8);
        #2;
        check("t4_b2_dout", bus.dout, 64'hC038_C037_C036_C035);
        tick();
        tick();

        // Asynchronous reset after 2 of 4 pixels
        send_px(14'h41, 1'b0, 1'b0);
        send_px(14'h42, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t5_busy", {63'd0, bus.busy}, 64'd0);
        check("t5_dout", bus.dout, 64'd0);
        for (int i = 1; i <= 4; i++) send_px(14'(8'h20 + i), i == 4, i == 4);
        #2;
        check("t5_wen",  {63'd0, bus.wen}, 64'd1);
        check("t5_dout_fresh", bus.dout, 64'h4024_0023_0022_8021);
        tick();
        tick();

        // clr wins over a simultaneous handshake
        send_px(14'h51, 1'b0, 1'b0);
        clr = 1'b1;
        bus.px_valid = 1'b1;
        bus.px_data  = 14'h52;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        bus.px_valid = 1'b0;
        #2;
        check("t6_busy",  {63'd0, bus.busy},     64'd0);
        check("t6_ready", {63'd0, bus.px_ready}, 64'd1);
        for (int i = 1; i <= 4; i++) send_px(14'(8'h60 + i), i == 4, i == 4);
        #2;
        check("t6_dout", bus.dout, 64'h4064_0063_0062_8061);
        tick();
        tick();

        // Continuous stream of 12 pixels: one bubble per 4 pixels
        @(negedge clk);
        acc_cyc_q.delete();
        for (int i = 1; i <= 12; i++) send_px(14'(8'h70 + i), i == 12, i == 12);
        span = acc_cyc_q[11] - acc_cyc_q[0];
        check("t7_span", 64'(span), 64'd13);
        tick();
        tick();

        // Randomized traffic with random back-pressure
        rand_full_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [DW-3:0] d;
            logic          l;
            logic          fl;
            d  = 14'($urandom_range(0, 16383));
            l  = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_px(d, l, fl);
        end
        send_px(14'h3FFF, 1'b1, 1'b1);
        rand_full_en = 1'b0;
        full_forced  = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        tick();
        tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
